sh7604_dmac_sched: RTL
======================

// Module: sh7604_dmac_sched
// PURPOSE
//  Request scheduler for the SH7604 on-chip DMAC channel pair. It detects DREQ/RXI/TXI/auto requests and latches
//  per-channel pending flags. It arbitrates ch0/ch1 with fixed or round-robin priority and issues one transfer-unit
//  grant at a time to the DMAC datapath (SAR/DAR/TCR sequencer), which answers with a done/last handshake.
//  Sits between DMAC register file (config inputs) and DMAC datapath; owns no bus signals itself.
// PARAMETERS
//  NUM_CH      2   channel count (only 2 supported; index width 1)
//  DREQ_SYNC   1   1: DREQx passes a 2-flop synchronizer before detection; 0: sampled directly
// PORTS
//  CLK        in   1  system clock
//  RST_N      in   1  asynchronous reset, active low
//  CE_R       in   1  rising-phase clock enable; all state updates gated by CE_R & EN
//  EN         in   1  global enable; 0 freezes all state (outputs hold)
//  DME        in   1  DMAOR.DME master enable
//  NMIF,AE    in   1  DMAOR.NMIF / DMAOR.AE abort flags
//  PR         in   1  DMAOR.PR: 0 fixed ch0>ch1, 1 round-robin
//  DE,TE      in   2  CHCRx.DE / CHCRx.TE per channel
//  AR,TB      in   2  CHCRx.AR auto-request / CHCRx.TB burst mode
//  DS,DL      in   2  CHCRx.DS (1=edge) / CHCRx.DL (1=active high)
//  RS0,RS1    in   2  DRCRx.RS: 00 DREQ, 01 RXI, 10 TXI, 11 none
//  DREQ0/1    in   1  external DMA request pins
//  RXI_IRQ,TXI_IRQ in 1  SCI receive/transmit request
//  XFER_DONE  in   1  datapath: current unit (incl. 4-LW burst) finished, valid on CE_R
//  XFER_LAST  in   1  datapath: qualifies XFER_DONE, TCR reached 0
//  GNT_VALID  out  1  grant active; datapath may start/continue a unit
//  GNT_CH     out  1  granted channel index
//  GNT_BURST  out  1  grant is held across units (TB of GNT_CH)
//  GNT_ABORT  out  1  granted channel lost eligibility; datapath finishes unit then stops
//  CH_PEND    out  2  latched pending flags
//  BUSY       out  1  state != IDLE
// BEHAVIOUR
//  Reset: GNT_VALID=0, GNT_CH=0, GNT_BURST=0, GNT_ABORT=0, CH_PEND=0, BUSY=0, RR_LAST=1 (ch0 served first), state IDLE.
//  ELIG[n] = DME & DE[n] & ~TE[n] & ~NMIF & ~AE (combinational).
//  Detect: DL=0 -> active=~DREQ; DL=1 -> active=DREQ. DS=0 level: REQ=active. DS=1 edge: REQ=active & ~prev_active.
//  Source sel: AR=1 -> 1; else by RSx (11 -> 0). Pend set on CE_R when ELIG & src; cleared by own XFER_DONE unless
//   AR=1; cleared immediately when ~ELIG. Set and clear same cycle: clear wins, except an edge REQ that cycle re-sets.
//  Latency: DREQ level active at CE_R k -> REQ reg k (k+2 with DREQ_SYNC) -> CH_PEND k+1 -> GNT_VALID k+2.
//  FSM (on CE_R & EN):
//   IDLE : any ELIG&PEND -> GRANT; GNT_CH = winner; PR=0 ch0 wins ties; PR=1 tie -> channel != RR_LAST.
//   GRANT: XFER_DONE & XFER_LAST -> IDLE; XFER_DONE & TB[GNT_CH] & PEND -> GRANT (same ch, no re-arb);
//          XFER_DONE otherwise -> IDLE; RR_LAST<=GNT_CH on every XFER_DONE. ~ELIG[GNT_CH] -> ABORT.
//   ABORT: GNT_ABORT=1, GNT_VALID=1; XFER_DONE -> IDLE. (also exits on XFER_LAST.)
//  IDLE always lasts >=1 CE_R cycle between non-burst grants (cycle-steal fairness).
//  GNT_CH/GNT_BURST stable while GNT_VALID=1; config changes mid-grant affect only next arbitration.
//  XFER_DONE while IDLE: ignored. Async reset mid-grant: all outputs to reset values next edge.
// STRUCTURE
//  SH7604_PKG: DMAC_SCHED_STATE_t enum {IDLE,GRANT,ABORT}; RS_DREQ/RS_RXI/RS_TXI/RS_NONE 2-bit constants.
//  Sub-module sh7604_dreq_detect (sync + level/edge + polarity), instantiated once per channel.
// TESTING
//  AR0=1,DE0,DME, XFER_DONE every grant, LAST on 3rd -> 3 grants ch0, then IDLE, TE0 path, CH_PEND0=0.
//  DL0=0,DS0=0 DREQ0 low at cyc 10 (SYNC=0) -> CH_PEND0=1 cyc 11, GNT_VALID=1 GNT_CH=0 cyc 12.
//  DS1=1,DL1=1 DREQ1 held high 20 cycles -> exactly one pend/grant; second pulse -> second grant.
//  PR=1, both AR=1, 6 DONEs -> GNT_CH sequence 0,1,0,1,0,1; PR=0 same -> 0,0,0,0,0,0.
//  TB0=1 AR0=1 -> GNT_VALID stays 1 across 4 DONEs with no IDLE gap; TB0=0 -> one IDLE cycle between grants.
//  Mid-grant NMIF=1 -> GNT_ABORT=1 next cycle, XFER_DONE -> IDLE, no further grants; RST_N low -> all outputs 0.

Source files
------------

// File: rtl/sh7604_dmac_sched_pkg.sv
// sh7604_dmac_sched_pkg: shared types and request-source helpers for the SH7604 DMAC scheduler
package sh7604_dmac_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} dmac_sched_state_t;
  localparam logic [1:0] RS_DREQ = 2'b00;
  localparam logic [1:0] RS_RXI  = 2'b01;
  localparam logic [1:0] RS_TXI  = 2'b10;
  localparam logic [1:0] RS_NONE = 2'b11;
  function automatic logic src_sel(input logic [1:0] rs, input logic req, input logic rxi, input logic txi);
    return rs == RS_NONE ? 1'b0 : rs == RS_TXI ? txi : rs == RS_RXI ? rxi : req;
  endfunction
endpackage

// File: rtl/sh7604_dmac_sched_dreq_detect.sv
// sh7604_dmac_sched_dreq_detect: DREQ polarity, optional 2-flop sync and level/edge request register
module sh7604_dmac_sched_dreq_detect #(
  parameter bit DREQ_SYNC = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic dreq,
  input  logic ds,
  input  logic dl,
  output logic req
);
  logic [1:0] sync;
  logic       prev;
  logic       pol;
  logic       act;
  // polarity is applied before the synchronizer so reset never reads as an active request
  assign pol = dl ? dreq : ~dreq;
  assign act = DREQ_SYNC ? sync[1] : pol;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      req  <= 1'b0;
    end else if (ce) begin
      sync <= {sync[0], pol};
      prev <= act;
      req  <= act & ~(ds & prev);
    end
  end
endmodule

// File: rtl/sh7604_dmac_sched.sv
// sh7604_dmac_sched: SH7604 DMAC request detection, pending flags and ch0/ch1 grant arbitration
module sh7604_dmac_sched
  import sh7604_dmac_sched_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter bit DREQ_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_r,
  input  logic              en,
  input  logic              dme,
  input  logic              nmif,
  input  logic              ae,
  input  logic              pr,
  input  logic [NUM_CH-1:0] de,
  input  logic [NUM_CH-1:0] te,
  input  logic [NUM_CH-1:0] ar,
  input  logic [NUM_CH-1:0] tb,
  input  logic [NUM_CH-1:0] ds,
  input  logic [NUM_CH-1:0] dl,
  input  logic [1:0]        rs0,
  input  logic [1:0]        rs1,
  input  logic              dreq0,
  input  logic              dreq1,
  input  logic              rxi_irq,
  input  logic              txi_irq,
  input  logic              xfer_done,
  input  logic              xfer_last,
  output logic              gnt_valid,
  output logic              gnt_ch,
  output logic              gnt_burst,
  output logic              gnt_abort,
  output logic [NUM_CH-1:0] ch_pend,
  output logic              busy
);
  dmac_sched_state_t        state;
  logic                     ce;
  logic                     rr_last;
  logic                     win;
  logic [NUM_CH-1:0]        req, elig, src, own, pend_d, cand, dreq_v;
  logic [NUM_CH-1:0][1:0]   rs_v;
  assign ce        = ce_r & en;
  assign dreq_v    = {dreq1, dreq0};
  assign rs_v      = {rs1, rs0};
  assign elig      = {NUM_CH{dme & ~nmif & ~ae}} & de & ~te;
  assign own       = {NUM_CH{gnt_valid & xfer_done}} & {gnt_ch, ~gnt_ch};
  assign cand      = elig & ch_pend;
  assign win       = &cand ? pr & ~rr_last : cand[1];
  assign gnt_valid = state != IDLE;
  assign gnt_abort = state == ABORT;
  assign busy      = gnt_valid;
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    sh7604_dmac_sched_dreq_detect #(.DREQ_SYNC(DREQ_SYNC)) u_det (
      .clk(clk), .rst_n(rst_n), .ce(ce), .dreq(dreq_v[n]), .ds(ds[n]), .dl(dl[n]), .req(req[n])
    );
    assign src[n] = ar[n] | src_sel(rs_v[n], req[n], rxi_irq, txi_irq);
    // a completed unit clears the flag, but a fresh DREQ edge in the same cycle must not be lost
    assign pend_d[n] = ~elig[n] ? 1'b0
                     : (own[n] & ~ar[n]) ? src[n] & ds[n] & (rs_v[n] == RS_DREQ)
                     : ch_pend[n] | src[n];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt_ch    <= 1'b0;
      gnt_burst <= 1'b0;
      ch_pend   <= '0;
      rr_last   <= 1'b1;
    end else if (ce) begin
      ch_pend <= pend_d;
      if (gnt_valid && xfer_done) rr_last <= gnt_ch;
      case (state)
        IDLE: if (|cand) begin
          state     <= GRANT;
          gnt_ch    <= win;
          gnt_burst <= tb[win];
        end
        GRANT: if (xfer_done) state <= (~xfer_last & gnt_burst & pend_d[gnt_ch]) ? GRANT : IDLE;
               else if (~elig[gnt_ch]) state <= ABORT;
        ABORT: if (xfer_done | xfer_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
